// File: rtl/digit_seq_detector.sv
// digit_seq_detector: runtime-programmable digit-sequence matcher with overlap control and saturating match counter
module digit_seq_detector #(
    parameter int DIGIT_W = 4,
    parameter int MAX_LEN = 8,
    parameter int CNT_W = 16,
    parameter logic [MAX_LEN*DIGIT_W-1:0] RESET_PATTERN = 32'h1131_6102,
    parameter int RESET_LEN = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic [DIGIT_W-1:0]           in_digit,
    input  logic                         overlap_en,
    input  logic                         cfg_digit_we,
    input  logic [$clog2(MAX_LEN)-1:0]   cfg_idx,
    input  logic [DIGIT_W-1:0]           cfg_digit,
    input  logic                         cfg_len_we,
    input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
    input  logic                         cnt_clr,
    output logic                         detected,
    output logic [CNT_W-1:0]             match_cnt,
    output logic [$clog2(MAX_LEN+1)-1:0] fill
);
    localparam int IDX_W = $clog2(MAX_LEN);
    localparam int LEN_W = $clog2(MAX_LEN+1);
    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

    logic [DIGIT_W-1:0] hist [MAX_LEN];
    logic [DIGIT_W-1:0] hist_n [MAX_LEN];
    logic [DIGIT_W-1:0] pat [MAX_LEN];
    logic [LEN_W-1:0]   len;
    logic [LEN_W-1:0]   fill_n;
    logic [LEN_W-1:0]   pidx;
    logic               match;
    logic               cfg;
    logic               hit;

    assign cfg = cfg_digit_we | cfg_len_we;
    assign hit = in_valid && !cfg && match;

    always_comb begin
        hist_n[0] = in_digit;
        for (int i = 1; i < MAX_LEN; i++) hist_n[i] = hist[i-1];
    end

    // age i of the incoming history lines up with pattern slot len-1-i
    always_comb begin
        fill_n = (fill == MAX_L) ? fill : fill + 1'b1;
        match = (len != '0) && (len <= MAX_L) && (fill_n >= len);
        pidx = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            pidx = len - LEN_W'(i) - 1'b1;
            if (LEN_W'(i) < len && hist_n[i] != pat[pidx[IDX_W-1:0]]) match = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= '{default: '0};
            for (int i = 0; i < MAX_LEN; i++) pat[i] <= RESET_PATTERN[i*DIGIT_W +: DIGIT_W];
            len <= LEN_W'(RESET_LEN);
            fill <= '0;
            detected <= 1'b0;
            match_cnt <= '0;
        end else begin
            if (cfg_digit_we && int'(cfg_idx) < MAX_LEN) pat[cfg_idx] <= cfg_digit;
            if (cfg_len_we) len <= cfg_len;
            detected <= hit;
            if (cfg) begin
                fill <= '0;
            end else if (in_valid) begin
                hist <= hist_n;
                fill <= (match && !overlap_en) ? '0 : fill_n;
            end
            if (cnt_clr) match_cnt <= hit ? CNT_W'(1) : '0;
            else if (hit && match_cnt != '1) match_cnt <= match_cnt + 1'b1;
        end
    end
endmodule
